// File: rtl/spi_oversample_core.sv
// Oversampled SPI slave: synchronises the pad signals onto clk, receives MSB-first words, and serves TX words from a one-word holding register.
// Optional sticky overrun/underrun status is compiled in when SPI_OVERSAMPLE_STATUS_EN is defined.
module spi_oversample_core #(
  parameter int   WIDTH       = 8,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sck,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] user_out,
  output logic             user_out_stb,
  input  logic [WIDTH-1:0] user_in,
  input  logic             user_in_valid,
  output logic             user_in_ready,
  output logic             csn_state,
  output logic             csn_rise,
  output logic             csn_fall
`ifdef SPI_OVERSAMPLE_STATUS_EN
  ,
  output logic             stat_overrun,
  output logic             stat_underrun,
  input  logic             stat_clr
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_csn_sync, r_fill;
  logic                   r_sck_prev, r_csn_prev, r_armed;
  logic                   r_csn_rise, r_csn_fall;
  state_t                 r_state, w_next;
  logic                   w_start;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WIDTH-2:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_user_out;
  logic                   r_stb;
  logic [WIDTH-1:0]       r_tx_shift, r_hold;
  logic                   r_hold_full, r_first, r_word_done;

  logic w_sck, w_mosi, w_csn;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_csn_fall, w_csn_rise, w_active;
  logic w_rx_bit, w_last_bit, w_tx_shift, w_load, w_accept;
  logic [WIDTH-1:0] w_word, w_load_word;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn  = r_csn_sync[SYNC_STAGES-1];

  // Synchronisers plus the previous-sample flops used for edge detection.
  // r_fill marks when w_csn reflects a real pad sample rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_csn_sync  <= '1;
      r_fill      <= '0;
      r_sck_prev  <= CPOL;
      r_csn_prev  <= 1'b1;
      r_armed     <= 1'b0;
      r_csn_rise  <= 1'b0;
      r_csn_fall  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sck_prev  <= w_sck;
      r_csn_prev  <= w_csn;
      r_armed     <= r_armed | (r_fill[SYNC_STAGES-1] & w_csn);
      r_csn_rise  <= w_csn_rise;
      r_csn_fall  <= w_csn_fall;
    end
  end

  assign w_lead        = (r_sck_prev == CPOL) && (w_sck != CPOL);
  assign w_trail       = (r_sck_prev != CPOL) && (w_sck == CPOL);
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead : w_trail;
  assign w_csn_fall    = r_csn_prev & ~w_csn;
  assign w_csn_rise    = ~r_csn_prev & w_csn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A fall is only honoured once CS_n has been seen high after reset.
  always_comb begin
    // NOTE: defaults first; a path that skipped an assignment would infer a latch.
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_csn_fall && r_armed) begin
          w_next  = ST_ACTIVE;
          w_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_csn_rise) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_active   = (r_state == ST_ACTIVE);
  assign w_rx_bit   = w_active & w_sample_edge;
  assign w_last_bit = w_rx_bit & (r_bit_cnt == LAST_BIT);
  assign w_word     = {r_rx_shift, w_mosi};

  // Receive path; the sample in the CS_n-rise cycle still counts, so a word ending there completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_user_out <= '0;
      r_stb      <= 1'b0;
    end else begin
      r_stb <= w_last_bit;
      if (w_rx_bit) begin
        r_rx_shift <= w_word[WIDTH-2:0];
        r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        if (w_last_bit) r_user_out <= w_word;
      end
      if (w_active && w_csn_rise) r_bit_cnt <= '0;
    end
  end

  assign w_tx_shift  = w_active & w_shift_edge;
  assign w_load      = w_start | (w_tx_shift & r_word_done);
  assign w_accept    = user_in_valid & ~r_hold_full;
  assign w_load_word = r_hold_full ? r_hold : '1;

  // Transmit path. With CPHA=1 the first leading edge only presents the MSB already loaded at CS_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_first     <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      if (w_accept) r_hold <= user_in;
      if (w_load) begin
        r_tx_shift  <= w_load_word;
        r_hold_full <= w_accept;
        r_first     <= w_start & CPHA;
      end else begin
        if (w_accept) r_hold_full <= 1'b1;
        if (w_tx_shift) begin
          if (r_first) r_first    <= 1'b0;
          else         r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        end
      end
      if (w_last_bit)  r_word_done <= 1'b1;
      else if (w_load) r_word_done <= 1'b0;
    end
  end

`ifdef SPI_OVERSAMPLE_STATUS_EN
  logic r_overrun, r_underrun, r_valid_seen;
  logic w_overrun_set, w_underrun_set;

  // Overrun: a word was delivered with no user_in_valid activity since the previous delivery.
  assign w_underrun_set = w_load & ~r_hold_full;
  assign w_overrun_set  = r_stb & ~(r_valid_seen | user_in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
      r_valid_seen <= 1'b0;
    end else begin
      r_valid_seen <= ~r_stb & (r_valid_seen | user_in_valid);
      r_overrun    <= w_overrun_set  | (r_overrun  & ~stat_clr);
      r_underrun   <= w_underrun_set | (r_underrun & ~stat_clr);
    end
  end

  assign stat_overrun  = r_overrun;
  assign stat_underrun = r_underrun;
`endif

  assign spi_miso      = r_tx_shift[WIDTH-1];
  assign spi_miso_oe   = ~w_csn;
  assign user_out      = r_user_out;
  assign user_out_stb  = r_stb;
  assign user_in_ready = ~r_hold_full;
  assign csn_state     = w_csn;
  assign csn_rise      = r_csn_rise;
  assign csn_fall      = r_csn_fall;

endmodule

// File: tb/tb_spi_oversample_core.sv
// Directed bench for spi_oversample_core: three instances (8-bit mode 0, 8-bit CPOL=1/CPHA=1, 12-bit mode 0)
// share clk, rst_n, SCK and MOSI; each has its own CS_n so only one is addressed at a time.
module tb_spi_oversample_core;

  localparam int HALF = 4;  // SCK half period in clk cycles (clk = 8x SCK)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n [3];
  logic [31:0] uin [3];
  logic        uin_valid [3];
  logic        stat_clr [3];

  logic [7:0]  uo0, uo1;
  logic [11:0] uo2;
  logic        miso0, miso1, miso2, oe0, oe1, oe2;
  logic        stb0, stb1, stb2, rdy0, rdy1, rdy2;
  logic        cst0, cst1, cst2, rise0, rise1, rise2, fall0, fall1, fall2;
`ifdef SPI_OVERSAMPLE_STATUS_EN
  logic        ovr0, ovr1, ovr2, und0, und1, und2;
`endif

  int n_checks = 0;
  int n_err = 0;
  int n_stb [3] = '{0, 0, 0};
  int n_rise0 = 0;
  logic [31:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  spi_oversample_core #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_n[0]),
    .spi_miso(miso0), .spi_miso_oe(oe0), .user_out(uo0), .user_out_stb(stb0),
    .user_in(uin[0][7:0]), .user_in_valid(uin_valid[0]), .user_in_ready(rdy0),
    .csn_state(cst0), .csn_rise(rise0), .csn_fall(fall0)
`ifdef SPI_OVERSAMPLE_STATUS_EN
    , .stat_overrun(ovr0), .stat_underrun(und0), .stat_clr(stat_clr[0])
`endif
  );

  spi_oversample_core #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .spi_sck(~sck), .spi_mosi(mosi), .spi_cs_n(cs_n[1]),
    .spi_miso(miso1), .spi_miso_oe(oe1), .user_out(uo1), .user_out_stb(stb1),
    .user_in(uin[1][7:0]), .user_in_valid(uin_valid[1]), .user_in_ready(rdy1),
    .csn_state(cst1), .csn_rise(rise1), .csn_fall(fall1)
`ifdef SPI_OVERSAMPLE_STATUS_EN
    , .stat_overrun(ovr1), .stat_underrun(und1), .stat_clr(stat_clr[1])
`endif
  );

  spi_oversample_core #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_n[2]),
    .spi_miso(miso2), .spi_miso_oe(oe2), .user_out(uo2), .user_out_stb(stb2),
    .user_in(uin[2][11:0]), .user_in_valid(uin_valid[2]), .user_in_ready(rdy2),
    .csn_state(cst2), .csn_rise(rise2), .csn_fall(fall2)
`ifdef SPI_OVERSAMPLE_STATUS_EN
    , .stat_overrun(ovr2), .stat_underrun(und2), .stat_clr(stat_clr[2])
`endif
  );

  // Count strobe cycles and capture delivered words, sampled on the inactive edge.
  always @(negedge clk) begin
    if (stb0) begin n_stb[0]++; q0.push_back(32'(uo0)); end
    if (stb1) begin n_stb[1]++; q1.push_back(32'(uo1)); end
    if (stb2) begin n_stb[2]++; q2.push_back(32'(uo2)); end
    if (rise0) n_rise0++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic miso_of(input int d);
    return (d == 0) ? miso0 : (d == 1) ? miso1 : miso2;
  endfunction

  function automatic logic ready_of(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction

  function automatic int width_of(input int d);
    return (d == 2) ? 12 : 8;
  endfunction

  task automatic pop_word(input int d, output logic [31:0] w);
    w = 32'hDEAD_BEEF;
    if (d == 0 && q0.size() > 0) w = q0.pop_front();
    if (d == 1 && q1.size() > 0) w = q1.pop_front();
    if (d == 2 && q2.size() > 0) w = q2.pop_front();
  endtask

  task automatic cs_set(input int d, input logic v);
    cs_n[d] = v;
    wait_clk(6);
  endtask

  // Bounded wait for ready, then a one-cycle valid; ready must drop afterwards.
  task automatic load_user(input int d, input logic [31:0] w);
    int b = 0;
    while (!ready_of(d) && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("ready_before_load", 32'(ready_of(d)), 32'd1);
    uin[d] = w;
    uin_valid[d] = 1'b1;
    @(negedge clk);
    uin_valid[d] = 1'b0;
    check("ready_after_load", 32'(ready_of(d)), 32'd0);
  endtask

  // SPI master: n bits of tx MSB-first; returns the bits read from MISO.
  task automatic xfer(input int d, input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (d == 1) begin
        mosi = tx[i];
        sck = 1'b1;
        wait_clk(HALF);
        rx = {rx[30:0], miso_of(d)};
        sck = 1'b0;
        wait_clk(HALF);
      end else begin
        mosi = tx[i];
        wait_clk(HALF);
        rx = {rx[30:0], miso_of(d)};
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
      end
    end
    wait_clk(HALF);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] mosi_w;
    logic        pre_en;
    logic [31:0] pre_w;
    logic [31:0] exp_out;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] rx, w;
    int stb_before, rise_before;

    vecs[0] = '{0, 32'hA5,  1'b0, 32'h00, 32'hA5, 32'hFF};
    vecs[1] = '{1, 32'h00,  1'b1, 32'h3C, 32'h00, 32'h3C};
    vecs[2] = '{0, 32'h5A,  1'b1, 32'hC3, 32'h5A, 32'hC3};
    vecs[3] = '{1, 32'h96,  1'b0, 32'h00, 32'h96, 32'hFF};
    vecs[4] = '{0, 32'h81,  1'b1, 32'h7E, 32'h81, 32'h7E};

    for (int i = 0; i < 3; i++) begin
      cs_n[i] = 1'b1;
      uin[i] = '0;
      uin_valid[i] = 1'b0;
      stat_clr[i] = 1'b0;
    end

    wait_clk(3);
    check("reset_user_out", 32'(uo0), 32'h0);
    check("reset_flags", {24'h0, stb0, rdy0, cst0, rise0, fall0, miso0, oe0, 1'b0}, {24'h0, 8'b0110_0000});
    check("reset_dut1_flags", {28'h0, stb1, rdy1, cst1, oe1}, {28'h0, 4'b0110});
    rst_n = 1'b1;
    wait_clk(8);

    // Single-word transfers across both modes, with and without a preloaded TX word.
    for (int i = 0; i < 5; i++) begin
      stb_before = n_stb[vecs[i].dut];
      if (vecs[i].pre_en) load_user(vecs[i].dut, vecs[i].pre_w);
      cs_set(vecs[i].dut, 1'b0);
      xfer(vecs[i].dut, width_of(vecs[i].dut), vecs[i].mosi_w, rx);
      cs_set(vecs[i].dut, 1'b1);
      pop_word(vecs[i].dut, w);
      check($sformatf("vec%0d_user_out", i), w, vecs[i].exp_out);
      check($sformatf("vec%0d_stb_count", i), 32'(n_stb[vecs[i].dut] - stb_before), 32'd1);
      check($sformatf("vec%0d_miso", i), rx, vecs[i].exp_miso);
`ifdef SPI_OVERSAMPLE_STATUS_EN
      if (i == 0) begin
        check("stat_underrun_set", 32'(und0), 32'd1);
        check("stat_overrun_set", 32'(ovr0), 32'd1);
        wait_clk(4);
        check("stat_underrun_sticky", 32'(und0), 32'd1);
        stat_clr[0] = 1'b1;
        @(negedge clk);
        stat_clr[0] = 1'b0;
        check("stat_cleared", {30'h0, und0, ovr0}, 32'h0);
      end
`endif
    end

    // 12-bit back-to-back words under one CS_n, refilling the holding register between words.
    stb_before = n_stb[2];
    load_user(2, 32'h5A5);
    cs_set(2, 1'b0);
    load_user(2, 32'h0F0);
    xfer(2, 12, 32'h123, rx);
    check("w12_miso0", rx, 32'h5A5);
    load_user(2, 32'h777);
    xfer(2, 12, 32'hABC, rx);
    check("w12_miso1", rx, 32'h0F0);
    xfer(2, 12, 32'hFFF, rx);
    check("w12_miso2", rx, 32'h777);
    cs_set(2, 1'b1);
    check("w12_stb_count", 32'(n_stb[2] - stb_before), 32'd3);
    pop_word(2, w);
    check("w12_word0", w, 32'h123);
    pop_word(2, w);
    check("w12_word1", w, 32'hABC);
    pop_word(2, w);
    check("w12_word2", w, 32'hFFF);

    // CS_n rise after 5 of 8 bits: no strobe, one csn_rise, held TX word survives.
    stb_before = n_stb[0];
    rise_before = n_rise0;
    cs_set(0, 1'b0);
    load_user(0, 32'h96);
    xfer(0, 5, 32'h1F, rx);
    cs_set(0, 1'b1);
    check("partial_no_stb", 32'(n_stb[0] - stb_before), 32'd0);
    check("partial_csn_rise", 32'(n_rise0 - rise_before), 32'd1);
    check("partial_hold_kept", 32'(rdy0), 32'd0);
    cs_set(0, 1'b0);
    xfer(0, 8, 32'h5A, rx);
    cs_set(0, 1'b1);
    pop_word(0, w);
    check("after_partial_word", w, 32'h5A);
    check("after_partial_miso", rx, 32'h96);

    // Reset mid-word, then release while CS_n is still low: nothing received until a fresh fall.
    cs_set(0, 1'b0);
    load_user(0, 32'h11);
    xfer(0, 4, 32'hF, rx);
    rst_n = 1'b0;
    #1;
    check("midrst_user_out", 32'(uo0), 32'h0);
    check("midrst_flags", {24'h0, stb0, rdy0, cst0, rise0, fall0, miso0, oe0, 1'b0}, {24'h0, 8'b0110_0000});
    check("midrst_dut2_out", 32'(uo2), 32'h0);
`ifdef SPI_OVERSAMPLE_STATUS_EN
    check("midrst_stats", {30'h0, und0, ovr0}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    stb_before = n_stb[0];
    wait_clk(4);
    xfer(0, 8, 32'hFF, rx);
    wait_clk(4);
    check("postrst_ignored", 32'(n_stb[0] - stb_before), 32'd0);
    cs_set(0, 1'b1);
    cs_set(0, 1'b0);
    xfer(0, 8, 32'h81, rx);
    cs_set(0, 1'b1);
    pop_word(0, w);
    check("postrst_word", w, 32'h81);
    check("postrst_miso", rx, 32'hFF);
    check("postrst_stb_count", 32'(n_stb[0] - stb_before), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_oversample_core.md
SPI_OVERSAMPLE_CORE -- requirements
Module: spi_oversample_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (4..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on SCK/MOSI/CS_n (2..3).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: spi_sck  in  1; spi_mosi  in  1; spi_cs_n  in  1; spi_miso  out  1; spi_miso_oe  out  1  (raw pad-side signals).
REQ-007 SHALL have ports: user_out  out  WIDTH  received word; user_out_stb  out  1  one-cycle valid pulse.
REQ-008 SHALL have ports: user_in  in  WIDTH  next TX word; user_in_valid  in  1; user_in_ready  out  1  TX holding register empty.
REQ-009 SHALL have ports: csn_state  out  1; csn_rise  out  1; csn_fall  out  1  (synchronised CS_n level and one-cycle edge pulses).

Function
REQ-010 SHALL pass spi_sck, spi_mosi, spi_cs_n through SYNC_STAGES flops on clk; all logic uses synchronised copies only; clk SHALL be >= 4x SCK frequency.
REQ-011 SHALL detect SCK edges from the last two synchronised samples; leading edge = transition away from CPOL level.
REQ-012 SHALL run a two-state FSM: IDLE (CS_n high) -> ACTIVE on synchronised CS_n fall; ACTIVE -> IDLE on CS_n rise; no other transitions.
REQ-013 In ACTIVE, SHALL sample MOSI into the RX shift register MSB-first on the sample edge; bit counter runs 0..WIDTH-1 and wraps to 0 after the last bit.
REQ-014 SHALL, on the sample edge of bit WIDTH-1, load user_out with the complete word and assert user_out_stb for exactly one cycle in the following clk cycle; user_out holds until the next word.
REQ-015 SHALL hold a one-word TX holding register; user_in_ready = 1 when empty; user_in accepted on the cycle user_in_valid & user_in_ready, then ready deasserts.
REQ-016 SHALL load the TX shift register from the holding register (emptying it) at CS_n fall and after the shift edge following bit WIDTH-1; if the holding register is empty, SHALL load all-ones.
REQ-017 SHALL drive spi_miso = TX shift register MSB; CPHA=0: first bit valid from load at CS_n fall, shift on trailing edges; CPHA=1: shift on leading edges, first bit presented on first leading edge.
REQ-018 SHALL drive spi_miso_oe = ~synchronised CS_n.
REQ-019 Accept and load in the same cycle: loaded word SHALL be the previously held word; newly accepted word SHALL occupy the holding register.
REQ-020 CS_n rise mid-word SHALL discard the partial RX word (no user_out_stb), reset bit counter, leave holding register contents intact.
REQ-021 CS_n rise coincident with bit WIDTH-1 sample edge SHALL still complete that word and pulse user_out_stb.
REQ-022 csn_rise/csn_fall SHALL pulse one cycle after the synchronised level changes; csn_state = synchronised level.

Reset
REQ-023 On rst_n low, SHALL asynchronously clear: FSM=IDLE, bit counter=0, shift registers=0, holding register empty (user_in_ready=1), user_out=0, user_out_stb=0, csn_rise=csn_fall=0, csn_state=1, synchronisers for CS_n=1 and SCK=CPOL.
REQ-024 Reset deassertion mid-transfer SHALL wait for a fresh CS_n fall before receiving.

Configuration
REQ-025 Macro SPI_OVERSAMPLE_STATUS_EN, when defined, SHALL add outputs stat_overrun (out 1) and stat_underrun (out 1) and input stat_clr (in 1).
REQ-026 With it: stat_underrun sets when REQ-016 loads all-ones, stat_overrun sets when user_out_stb fires while previous word unread is unknowable, so defined as stb with user_in_valid never asserted since last stb; both sticky, cleared by stat_clr, stat_clr loses to simultaneous set; reset clears both.
REQ-027 Without it, ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 WIDTH=8, CPOL=0, CPHA=0, clk=8x SCK: master sends 0xA5 -> user_out=0xA5, one user_out_stb pulse.
REQ-029 user_in=0x3C preloaded before CS_n fall, CPHA=1, CPOL=1 -> master reads 0x3C while sending 0x00.
REQ-030 Holding register empty at word boundary -> master reads 0xFF; with STATUS_EN stat_underrun=1 until stat_clr.
REQ-031 WIDTH=12, three back-to-back words 0x123, 0xABC, 0xFFF under one CS_n -> three stb pulses in order, counter wraps.
REQ-032 CS_n rise after 5 of 8 bits -> no stb, csn_rise pulses once; next transfer 0x5A received correctly.
REQ-033 rst_n asserted mid-word -> all outputs at REQ-023 values immediately; next full transfer 0x81 received correctly.
